alu_shift_seq: RTL and testbench
================================

Name: alu_shift_seq

Overview:
- Microcode-side sequencer directly upstream of the ALU. It issues the two-line ALU control sequence (load/shift line, then high-nibble/result line) for CB-prefix rotate and shift ops: RLC, RRC, RL, RR, SLA, SRA, SRL.
- It captures the ALU's shift-out bit, result and zero outputs, and presents the 8-bit result plus new Z/N/H/C flags with a start/done handshake.

Parameters:
- FLAGS_W, 4, width of flag vector {Z,N,H,C}

Ports:
- clk  in  1  clock; all state changes on rising edge
- nreset  in  1  asynchronous, active-low reset
- start  in  1  request; accepted only in IDLE
- abort  in  1  synchronous cancel of an in-flight op
- op  in  3  0 RLC, 1 RRC, 2 RL, 3 RR, 4 SLA, 5 SRA, 6 reserved, 7 SRL
- operand  in  8  source byte, sampled at accepted start
- c_in  in  1  current carry flag, sampled at accepted start
- alu_op  out  8  ALU operand bus
- alu_si  out  1  ALU shift-in bit
- alu_sh  out  sh_t  shift direction (L_SH/R_SH)
- alu_oe  out  oe_t  ALU output select (NO_OE/SH_OE/RES_OE)
- alu_la, alu_lb  out  ld_t  latch controls (NO_LD/BUS_LD)
- alu_l, alu_h  out  1  low/high nibble phase strobes
- alu_r, alu_s, alu_v, alu_ne, alu_ci  out  1  fixed ALU mode bits
- shift_dbl  in  1  ALU shift-out bit, valid during LOAD line
- result  in  8  ALU result, valid during HIGH line
- zero  in  1  ALU zero, valid during HIGH line
- busy  out  1  high in LOAD, HIGH
- done  out  1  one-cycle pulse when res/flags are updated
- err  out  1  one-cycle pulse when a start with op=6 is rejected
- res  out  8  last completed result
- flags  out  FLAGS_W  last completed {Z,N,H,C}

Behaviour:
- Reset: state IDLE, all outputs 0. ALU lines are idle: la/lb=NO_LD, oe=NO_OE, l=h=0.
- FSM: IDLE -> LOAD -> HIGH -> IDLE.
  - start in IDLE with a valid op: latch operand, op and c_in, go to LOAD.
  - start with op=6: err pulses next cycle, state stays IDLE.
- LOAD line (cycle T+1 after start at T):
  - alu_op=operand.
  - alu_sh = L_SH for ops 0, 2, 4; R_SH otherwise.
  - alu_oe=SH_OE, la=lb=BUS_LD, l=1, h=0.
  - r=s=v=1, ne=ci=0.
  - alu_si: RLC operand[7]; RRC operand[0]; RL/RR c_in; SLA 0; SRA operand[7]; SRL 0.
  - Register shift_dbl as the new carry.
- HIGH line (T+2): la=lb=NO_LD, oe=RES_OE, l=0, h=1, r=s=v=1, ne=ci=0. Register result and zero.
- T+3: state IDLE, done=1.
  - res = captured result.
  - flags: Z=captured zero, N=0, H=0, C=captured shift_dbl.
  - res/flags hold until the next done.
- Total latency start-to-done: 3 cycles. Throughput: one op per 3 cycles. A start in the done cycle is accepted, since the FSM is already IDLE.
- start while busy: ignored, no queueing.
- abort in LOAD/HIGH: next state IDLE, no done, res/flags unchanged, ALU lines idle next cycle. If abort and start arrive together in IDLE, abort wins and start is dropped.
- nreset asserted mid-op: immediate IDLE, outputs cleared including res/flags.
- alu_op is driven only in LOAD and is 0 otherwise; no X on any output in any state.

Decomposition:
- Shared alu package (existing) owns sh_t, oe_t, ld_t and the constants L_SH, R_SH, SH_OE, RES_OE, NO_OE, BUS_LD, NO_LD.
- New in same package:
  - cb_shift_op_t enum with the 3-bit op encodings;
  - flag bit index constants FLAG_Z, FLAG_N, FLAG_H, FLAG_C.
- One combinational sub-module, alu_shift_line_gen: maps (state, op, operand, c_in) to the ALU control-line outputs. The FSM and capture registers stay in the top.

Test Plan:
(Bench pairs the block with the real ALU.)
- RR, operand=0x81, c_in=1 -> LOAD si=1, sh=R_SH; T+2 result=0xC0; T+3 done=1, res=0xC0, flags Z=0, N=0, H=0, C=1.
- RLC, operand=0x80 -> si=1, shift_dbl=1; res=0x01, C=1, Z=0.
- SRL, operand=0x01 -> res=0x00, Z=1, C=1. SRA, operand=0x80 -> res=0xC0, C=0.
- Start RL at T, start again at T+1 with different operand -> second start ignored; one done at T+3 with first result; busy=1 on T+1..T+2.
- Start SLA 0xFF, abort at T+2 -> no done, res/flags keep prior values, alu_oe=NO_OE at T+3. Separately, op=6 -> err=1 one cycle, busy stays 0.
- nreset low during HIGH -> same cycle all outputs 0, state IDLE. A later start of RRC 0x01 -> res=0x80, C=1.

Source files
------------

// File: rtl/alu_shift_seq_pkg.sv
// Shared ALU control types plus the CB-prefix rotate/shift op encodings and flag layout.
package alu_shift_seq_pkg;

    typedef enum logic {L_SH = 1'b0, R_SH = 1'b1} sh_t;
    typedef enum logic [1:0] {NO_OE = 2'd0, SH_OE = 2'd1, RES_OE = 2'd2} oe_t;
    typedef enum logic {NO_LD = 1'b0, BUS_LD = 1'b1} ld_t;

    typedef enum logic [2:0] {
        OP_RLC  = 3'd0,
        OP_RRC  = 3'd1,
        OP_RL   = 3'd2,
        OP_RR   = 3'd3,
        OP_SLA  = 3'd4,
        OP_SRA  = 3'd5,
        OP_RSVD = 3'd6,
        OP_SRL  = 3'd7
    } cb_shift_op_t;

    typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_LOAD = 2'd1, ST_HIGH = 2'd2} seq_state_t;

    localparam int FLAG_Z = 3;
    localparam int FLAG_N = 2;
    localparam int FLAG_H = 1;
    localparam int FLAG_C = 0;

    function automatic sh_t shift_dir(input cb_shift_op_t op);
        case (op)
            OP_RLC, OP_RL, OP_SLA: return L_SH;
            default:               return R_SH;
        endcase
    endfunction

    // Bit fed into the vacated end: rotates recycle the operand, RL/RR go through carry,
    // SRA keeps the sign, logical shifts fill with zero.
    function automatic logic shift_in(input cb_shift_op_t op, input logic [7:0] operand,
                                      input logic c_in);
        case (op)
            OP_RLC:       return operand[7];
            OP_RRC:       return operand[0];
            OP_RL, OP_RR: return c_in;
            OP_SRA:       return operand[7];
            default:      return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/alu_shift_line_gen.sv
// Combinational decode of sequencer state and latched op into the two ALU control lines.
module alu_shift_line_gen
    import alu_shift_seq_pkg::*;
(
    input  seq_state_t   state,
    input  cb_shift_op_t op,
    input  logic [7:0]   operand,
    input  logic         c_in,
    output logic [7:0]   alu_op,
    output logic         alu_si,
    output sh_t          alu_sh,
    output oe_t          alu_oe,
    output ld_t          alu_la,
    output ld_t          alu_lb,
    output logic         alu_l,
    output logic         alu_h,
    output logic         alu_r,
    output logic         alu_s,
    output logic         alu_v,
    output logic         alu_ne,
    output logic         alu_ci
);

    always_comb begin
        alu_op = 8'h00;
        alu_si = 1'b0;
        alu_sh = L_SH;
        alu_oe = NO_OE;
        alu_la = NO_LD;
        alu_lb = NO_LD;
        alu_l  = 1'b0;
        alu_h  = 1'b0;
        alu_r  = 1'b0;
        alu_s  = 1'b0;
        alu_v  = 1'b0;
        alu_ne = 1'b0;
        alu_ci = 1'b0;
        case (state)
            ST_LOAD: begin
                alu_op = operand;
                alu_si = shift_in(op, operand, c_in);
                alu_sh = shift_dir(op);
                alu_oe = SH_OE;
                alu_la = BUS_LD;
                alu_lb = BUS_LD;
                alu_l  = 1'b1;
                alu_r  = 1'b1;
                alu_s  = 1'b1;
                alu_v  = 1'b1;
            end
            ST_HIGH: begin
                alu_oe = RES_OE;
                alu_h  = 1'b1;
                alu_r  = 1'b1;
                alu_s  = 1'b1;
                alu_v  = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/alu_shift_seq.sv
// CB rotate/shift sequencer: drives LOAD then HIGH ALU lines, captures result and flags.
module alu_shift_seq
    import alu_shift_seq_pkg::*;
#(
    parameter int FLAGS_W = 4
) (
    input  logic               clk,
    input  logic               nreset,
    input  logic               start,
    input  logic               abort,
    input  logic [2:0]         op,
    input  logic [7:0]         operand,
    input  logic               c_in,
    output logic [7:0]         alu_op,
    output logic               alu_si,
    output sh_t                alu_sh,
    output oe_t                alu_oe,
    output ld_t                alu_la,
    output ld_t                alu_lb,
    output logic               alu_l,
    output logic               alu_h,
    output logic               alu_r,
    output logic               alu_s,
    output logic               alu_v,
    output logic               alu_ne,
    output logic               alu_ci,
    input  logic               shift_dbl,
    input  logic [7:0]         result,
    input  logic               zero,
    output logic               busy,
    output logic               done,
    output logic               err,
    output logic [7:0]         res,
    output logic [FLAGS_W-1:0] flags
);

    seq_state_t         state, next_state;
    cb_shift_op_t       op_q;
    logic [7:0]         operand_q;
    logic               cin_q;
    logic               carry_q;
    logic               accept, reject;
    logic [FLAGS_W-1:0] new_flags;

    // abort in IDLE suppresses both acceptance and the reserved-op error
    assign accept = (state == ST_IDLE) && start && !abort && (cb_shift_op_t'(op) != OP_RSVD);
    assign reject = (state == ST_IDLE) && start && !abort && (cb_shift_op_t'(op) == OP_RSVD);

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) state <= ST_IDLE;
        else         state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE: if (accept) next_state = ST_LOAD;
            ST_LOAD: next_state = abort ? ST_IDLE : ST_HIGH;
            ST_HIGH: next_state = ST_IDLE;
            default: next_state = ST_IDLE;
        endcase
    end

    always_comb begin
        busy = (state == ST_LOAD) || (state == ST_HIGH);
    end

    always_comb begin
        new_flags         = '0;
        new_flags[FLAG_Z] = zero;
        new_flags[FLAG_C] = carry_q;
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            op_q      <= OP_RLC;
            operand_q <= 8'h00;
            cin_q     <= 1'b0;
            carry_q   <= 1'b0;
            res       <= 8'h00;
            flags     <= '0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            done <= 1'b0;
            err  <= reject;
            if (accept) begin
                op_q      <= cb_shift_op_t'(op);
                operand_q <= operand;
                cin_q     <= c_in;
            end
            if (state == ST_LOAD) carry_q <= shift_dbl;
            if (state == ST_HIGH && !abort) begin
                res   <= result;
                flags <= new_flags;
                done  <= 1'b1;
            end
        end
    end

    alu_shift_line_gen u_line_gen (
        .state   (state),
        .op      (op_q),
        .operand (operand_q),
        .c_in    (cin_q),
        .alu_op  (alu_op),
        .alu_si  (alu_si),
        .alu_sh  (alu_sh),
        .alu_oe  (alu_oe),
        .alu_la  (alu_la),
        .alu_lb  (alu_lb),
        .alu_l   (alu_l),
        .alu_h   (alu_h),
        .alu_r   (alu_r),
        .alu_s   (alu_s),
        .alu_v   (alu_v),
        .alu_ne  (alu_ne),
        .alu_ci  (alu_ci)
    );

endmodule

// File: tb/tb_alu_shift_seq.sv
// Bench for alu_shift_seq paired with a small behavioural ALU; results scored against a queue.
module tb_alu_shift_seq;
    import alu_shift_seq_pkg::*;

    logic       clk = 1'b0;
    logic       nreset = 1'b0;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic [2:0] op = 3'd0;
    logic [7:0] operand = 8'h00;
    logic       c_in = 1'b0;
    logic [7:0] alu_op;
    logic       alu_si;
    sh_t        alu_sh;
    oe_t        alu_oe;
    ld_t        alu_la, alu_lb;
    logic       alu_l, alu_h, alu_r, alu_s, alu_v, alu_ne, alu_ci;
    logic       shift_dbl;
    logic [7:0] result;
    logic       zero;
    logic       busy, done, err;
    logic [7:0] res;
    logic [3:0] flags;

    int checks = 0;
    int errors = 0;
    logic [11:0] sb_q[$];
    logic [7:0]  last_res = 8'h00;
    logic [3:0]  last_flags = 4'h0;

    always #5 clk = ~clk;

    alu_shift_seq #(.FLAGS_W(4)) dut (
        .clk(clk), .nreset(nreset), .start(start), .abort(abort), .op(op),
        .operand(operand), .c_in(c_in), .alu_op(alu_op), .alu_si(alu_si),
        .alu_sh(alu_sh), .alu_oe(alu_oe), .alu_la(alu_la), .alu_lb(alu_lb),
        .alu_l(alu_l), .alu_h(alu_h), .alu_r(alu_r), .alu_s(alu_s), .alu_v(alu_v),
        .alu_ne(alu_ne), .alu_ci(alu_ci), .shift_dbl(shift_dbl), .result(result),
        .zero(zero), .busy(busy), .done(done), .err(err), .res(res), .flags(flags)
    );

    // Behavioural ALU: shifts the bus on the LOAD line, presents the latched byte on RES_OE.
    logic [7:0] alu_reg = 8'h00;
    logic [7:0] shifted;
    always_comb begin
        shift_dbl = (alu_sh == L_SH) ? alu_op[7] : alu_op[0];
        shifted   = (alu_sh == L_SH) ? {alu_op[6:0], alu_si} : {alu_si, alu_op[7:1]};
    end
    always @(posedge clk) if (alu_la == BUS_LD && alu_oe == SH_OE) alu_reg <= shifted;
    assign result = (alu_oe == RES_OE) ? alu_reg : 8'h00;
    assign zero   = (alu_oe == RES_OE) && (alu_reg == 8'h00);

    // Reference: {res[7:0], Z, N, H, C} from the op's arithmetic definition.
    function automatic logic [11:0] ref_model(input int o, input int x, input int cin);
        int r, c;
        r = 0; c = 0;
        case (o)
            0: begin r = (x * 2) + (x / 128);         c = x / 128; end
            1: begin r = (x / 2) + (x % 2) * 128;     c = x % 2;   end
            2: begin r = (x * 2) + cin;               c = x / 128; end
            3: begin r = (x / 2) + cin * 128;         c = x % 2;   end
            4: begin r = x * 2;                       c = x / 128; end
            5: begin r = (x / 2) + (x / 128) * 128;   c = x % 2;   end
            7: begin r = x / 2;                       c = x % 2;   end
            default: ;
        endcase
        r = r % 256;
        return {r[7:0], (r == 0), 1'b0, 1'b0, c[0]};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Called #1 after an edge: drives start for exactly one active edge.
    task automatic issue(input int o, input int x, input int cin);
        start = 1'b1; op = 3'(o); operand = 8'(x); c_in = cin[0];
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic run_op(input int o, input int x, input int cin);
        logic [11:0] e;
        e = ref_model(o, x, cin);
        sb_q.push_back(e);
        last_res = e[11:4];
        last_flags = e[3:0];
        issue(o, x, cin);
        @(posedge clk); #1;
        @(posedge clk); #1;
    endtask

    always @(negedge clk) begin
        if (nreset && done) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got done=1 expected no done at %0t", $time);
            end else begin
                logic [11:0] e;
                e = sb_q.pop_front();
                chk("done_res", res, e[11:4]);
                chk("done_flags", flags, e[3:0]);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int ops[7] = '{0, 1, 2, 3, 4, 5, 7};
        #12;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_res", res, 0);
        chk("rst_flags", flags, 0);
        chk("rst_oe", alu_oe, NO_OE);
        chk("rst_la", alu_la, NO_LD);
        chk("rst_lines", {alu_op, alu_l, alu_h, alu_r, alu_s, alu_v, err}, 0);
        nreset = 1'b1;
        @(posedge clk); #1;

        // RR 0x81 with carry: check the LOAD and HIGH lines directly
        sb_q.push_back(ref_model(3, 'h81, 1));
        issue(3, 'h81, 1);
        chk("load_si", alu_si, 1);
        chk("load_sh", alu_sh, R_SH);
        chk("load_oe", alu_oe, SH_OE);
        chk("load_op", alu_op, 'h81);
        chk("load_ctl", {alu_la, alu_lb, alu_l, alu_h, alu_r, alu_s, alu_v, alu_ne, alu_ci}, 9'b111011100);
        chk("load_busy", busy, 1);
        @(posedge clk); #1;
        chk("high_oe", alu_oe, RES_OE);
        chk("high_ctl", {alu_la, alu_lb, alu_l, alu_h, alu_r, alu_s, alu_v, alu_ne, alu_ci}, 9'b000111100);
        chk("high_op", alu_op, 0);
        @(posedge clk); #1;
        chk("rr_done", done, 1);
        chk("rr_res", res, 'hC0);
        chk("rr_flags", flags, 4'b0001);

        run_op(0, 'h80, 0);
        run_op(7, 'h01, 0);
        run_op(5, 'h80, 0);

        // second start while busy is dropped
        begin
            logic [11:0] e;
            e = ref_model(2, 'h55, 0);
            sb_q.push_back(e);
            last_res = e[11:4]; last_flags = e[3:0];
        end
        issue(2, 'h55, 0);
        chk("busy_t1", busy, 1);
        start = 1'b1; op = 3'd2; operand = 8'hAA; c_in = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("busy_t2", busy, 1);
        @(posedge clk); #1;
        chk("busy_done", busy, 0);
        @(posedge clk); #1;
        chk("no_second_op", busy, 0);

        // abort during HIGH: no done, results held, lines idle
        issue(4, 'hFF, 0);
        @(posedge clk); #1;
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        chk("abort_oe", alu_oe, NO_OE);
        chk("abort_done", done, 0);
        chk("abort_busy", busy, 0);
        chk("abort_res", res, last_res);
        chk("abort_flags", flags, last_flags);

        // reserved op raises a one-cycle err
        start = 1'b1; op = 3'd6; operand = 8'h12;
        @(posedge clk); #1;
        start = 1'b0;
        chk("err_pulse", err, 1);
        chk("err_busy", busy, 0);
        @(posedge clk); #1;
        chk("err_clear", err, 0);

        // abort beats a simultaneous start
        start = 1'b1; abort = 1'b1; op = 3'd2; operand = 8'h33;
        @(posedge clk); #1;
        start = 1'b0; abort = 1'b0;
        chk("abort_start_busy", busy, 0);

        // asynchronous reset in HIGH
        issue(3, 'h81, 1);
        @(posedge clk); #1;
        nreset = 1'b0;
        #1;
        chk("arst_busy", busy, 0);
        chk("arst_res", res, 0);
        chk("arst_flags", flags, 0);
        chk("arst_oe", alu_oe, NO_OE);
        chk("arst_h", alu_h, 0);
        #2;
        nreset = 1'b1;
        @(posedge clk); #1;
        run_op(1, 'h01, 0);
        chk("rrc_res", res, 'h80);
        chk("rrc_flags", flags, 4'b0001);

        // randomized back-to-back ops, each start in the previous done cycle
        for (int i = 0; i < 40; i++) begin
            run_op(ops[$urandom_range(0, 6)], int'($urandom_range(0, 255)), int'($urandom_range(0, 1)));
        end

        repeat (4) @(posedge clk);
        #1;
        chk("sb_empty", sb_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
